// File: rtl/fpu_defs.sv
// ---------------------------------------------------------------------------
// fpu_defs: shared definitions for the single-precision PCPI FPU units.
//   - FMUL.S decode constants (opcode, funct7) and a decode helper
//   - binary32 field widths, exponent bias, canonical NaN and inf patterns
//   - FSM state encoding shared by the multi-cycle units
// No ports (package).
// ---------------------------------------------------------------------------
package fpu_defs;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [6:0]  FMUL_OPCODE = 7'b1010011;
  localparam logic [6:0]  FMUL_FUNCT7 = 7'b0001000;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF   = 32'hFF80_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_MUL    = 3'd2,
    ST_NORM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_HOLD   = 3'd5
  } fsm_state_e;

  // rm[14:12] and the register fields do not take part in the match.
  function automatic logic is_fmul(input logic [6:0] funct7, input logic [6:0] opcode);
    return (opcode == FMUL_OPCODE) && (funct7 == FMUL_FUNCT7);
  endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// ---------------------------------------------------------------------------
// fpu_round_pack: combinational round-to-nearest-even, overflow/underflow
// clamp and binary32 field packing.
//   sign_i    result sign
//   exp_i     biased exponent before rounding (10-bit signed)
//   man_i     24-bit mantissa including the hidden bit (bit 23)
//   guard_i   first discarded bit
//   round_i   second discarded bit
//   sticky_i  OR of all remaining discarded bits
//   result_o  packed binary32 result
//   of_o      overflow (result clamped to signed inf)
//   uf_o      underflow (result flushed to signed zero)
//   nx_o      inexact
// ---------------------------------------------------------------------------
module fpu_round_pack
  import fpu_defs::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [23:0]       man_i,
  input  logic              guard_i,
  input  logic              round_i,
  input  logic              sticky_i,
  output logic [31:0]       result_o,
  output logic              of_o,
  output logic              uf_o,
  output logic              nx_o
);

  logic              round_up;
  logic [24:0]       man_rnd;
  logic [MAN_W-1:0]  man_fin;
  logic signed [9:0] exp_fin;
  logic              inexact;

  always_comb begin
    // Ties go to the even mantissa: bump only if something beyond the
    // guard bit is set or the current LSB is odd.
    round_up = guard_i & (round_i | sticky_i | man_i[0]);
    man_rnd  = {1'b0, man_i} + {24'd0, round_up};
    inexact  = guard_i | round_i | sticky_i;

    // 1.111..1 + ulp carries into bit 24: the mantissa becomes 1.000..0
    // and the exponent goes up by one.
    if (man_rnd[24]) begin
      man_fin = man_rnd[23:1];
      exp_fin = exp_i + 10'sd1;
    end else begin
      man_fin = man_rnd[22:0];
      exp_fin = exp_i;
    end

    of_o = (exp_fin >= 10'sd255);
    uf_o = (exp_fin <= 10'sd0);
    nx_o = inexact | of_o | uf_o;

    if (of_o) begin
      result_o = {sign_i, 8'hFF, 23'd0};
    end else if (uf_o) begin
      result_o = {sign_i, 31'd0};
    end else begin
      result_o = {sign_i, exp_fin[EXP_W-1:0], man_fin};
    end
  end

endmodule

// File: rtl/pcpi_fmul.sv
// ---------------------------------------------------------------------------
// pcpi_fmul: picorv32 PCPI coprocessor executing FMUL.S on raw binary32
// bit patterns held in integer registers. Round-to-nearest-even always,
// subnormal inputs and outputs flushed to signed zero.
//
// Handshake: an instruction is accepted on a clock edge where pcpi_valid is
// high, the FSM is idle and the insn decodes as FMUL.S. pcpi_wait is high
// from the cycle after acceptance until the result cycle; in the result
// cycle pcpi_ready and pcpi_wr are high for exactly one clock with pcpi_rd
// valid. pcpi_valid is not required to stay high after acceptance, and is
// ignored for one cycle after the result so a lagging valid cannot retrigger.
//
// Parameter MUL_STAGES (1..3): pipeline registers in the mantissa multiplier.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   pcpi_valid/insn/rs1/rs2   request from the core
//   pcpi_wr/rd/wait/ready     response to the core
//   dbg_state         current FSM state (fsm_state_e encoding)
//   fflags[4:0]       {NV,DZ,OF,UF,NX}, only when FMUL_FLAGS_EN is defined
// Optional feature macro: FMUL_FLAGS_EN.
// ---------------------------------------------------------------------------
module pcpi_fmul
  import fpu_defs::*;
#(
  parameter int MUL_STAGES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [2:0]  dbg_state
`ifdef FMUL_FLAGS_EN
  ,
  output logic [4:0]  fflags
`endif
);

  localparam logic [1:0] MUL_LAST = 2'(MUL_STAGES - 1);

  fsm_state_e        state_q, state_d;
  logic [31:0]       rs1_q, rs1_d, rs2_q, rs2_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [23:0]       man_a_q, man_a_d, man_b_q, man_b_d;
  logic              special_q, special_d;
  logic [31:0]       special_val_q, special_val_d;
  logic              nv_q, nv_d;
  logic [47:0]       prod_q [MUL_STAGES];
  logic [47:0]       prod_d [MUL_STAGES];
  logic [1:0]        mul_cnt_q, mul_cnt_d;
  logic [31:0]       res_q, res_d;
  logic              wr_q, wr_d, ready_q, ready_d, wait_q, wait_d;
  logic [31:0]       rd_q, rd_d;

  // Unpacked operand fields.
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_any;

  // Normalisation path.
  logic [47:0]       prod;
  logic signed [9:0] norm_exp;
  logic [23:0]       norm_man;
  logic              norm_g, norm_r, norm_s;
  logic [31:0]       rp_result;
  logic              rp_of, rp_uf, rp_nx;

  logic unused_insn;
  assign unused_insn = ^pcpi_insn[24:7];

  always_comb begin
    ea = rs1_q[30:23];
    eb = rs2_q[30:23];
    fa = rs1_q[22:0];
    fb = rs2_q[22:0];
    // Exponent zero covers true zero and subnormals, both treated as zero.
    zero_a   = (ea == 8'd0);
    zero_b   = (eb == 8'd0);
    inf_a    = (ea == 8'hFF) && (fa == 23'd0);
    inf_b    = (eb == 8'hFF) && (fb == 23'd0);
    nan_a    = (ea == 8'hFF) && (fa != 23'd0);
    nan_b    = (eb == 8'hFF) && (fb != 23'd0);
    snan_any = (nan_a && !fa[22]) || (nan_b && !fb[22]);
  end

  always_comb begin
    prod = prod_q[MUL_STAGES-1];
    // 1.x * 1.y lies in [1,4): bit 47 set means the product is >= 2.
    if (prod[47]) begin
      norm_man = prod[47:24];
      norm_g   = prod[23];
      norm_r   = prod[22];
      norm_s   = |prod[21:0];
      norm_exp = exp_q + 10'sd1;
    end else begin
      norm_man = prod[46:23];
      norm_g   = prod[22];
      norm_r   = prod[21];
      norm_s   = |prod[20:0];
      norm_exp = exp_q;
    end
  end

  fpu_round_pack u_round_pack (
    .sign_i   (sign_q),
    .exp_i    (norm_exp),
    .man_i    (norm_man),
    .guard_i  (norm_g),
    .round_i  (norm_r),
    .sticky_i (norm_s),
    .result_o (rp_result),
    .of_o     (rp_of),
    .uf_o     (rp_uf),
    .nx_o     (rp_nx)
  );

  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    man_a_d       = man_a_q;
    man_b_d       = man_b_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    nv_d          = nv_q;
    mul_cnt_d     = mul_cnt_q;
    res_d         = res_q;
    wr_d          = 1'b0;
    ready_d       = 1'b0;
    wait_d        = wait_q;
    rd_d          = rd_q;

    // Multiplier pipeline advances every cycle; its operands are stable
    // from UNPACK until the FSM leaves NORM.
    prod_d[0] = {24'd0, man_a_q} * {24'd0, man_b_q};
    for (int i = 1; i < MUL_STAGES; i++) begin
      prod_d[i] = prod_q[i-1];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pcpi_valid && is_fmul(pcpi_insn[31:25], pcpi_insn[6:0])) begin
          rs1_d   = pcpi_rs1;
          rs2_d   = pcpi_rs2;
          wait_d  = 1'b1;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_d    = rs1_q[31] ^ rs2_q[31];
        exp_d     = $signed({2'b00, ea} + {2'b00, eb} - 10'd127);
        man_a_d   = zero_a ? 24'd0 : {1'b1, fa};
        man_b_d   = zero_b ? 24'd0 : {1'b1, fb};
        special_d = 1'b1;
        nv_d      = 1'b0;
        if (nan_a || nan_b) begin
          special_val_d = CANON_NAN;
          nv_d          = snan_any;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
          special_val_d = CANON_NAN;
          nv_d          = 1'b1;
        end else if (inf_a || inf_b) begin
          special_val_d = sign_d ? NEG_INF : POS_INF;
        end else if (zero_a || zero_b) begin
          special_val_d = {sign_d, 31'd0};
        end else begin
          special_d     = 1'b0;
          special_val_d = 32'd0;
        end
        mul_cnt_d = 2'd0;
        state_d   = ST_MUL;
      end
      ST_MUL: begin
        mul_cnt_d = mul_cnt_q + 2'd1;
        if (mul_cnt_q == MUL_LAST) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        res_d   = special_q ? special_val_q : rp_result;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rd_d    = res_q;
        wr_d    = 1'b1;
        ready_d = 1'b1;
        wait_d  = 1'b0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      rs1_q         <= 32'd0;
      rs2_q         <= 32'd0;
      sign_q        <= 1'b0;
      exp_q         <= 10'sd0;
      man_a_q       <= 24'd0;
      man_b_q       <= 24'd0;
      special_q     <= 1'b0;
      special_val_q <= 32'd0;
      nv_q          <= 1'b0;
      mul_cnt_q     <= 2'd0;
      res_q         <= 32'd0;
      wr_q          <= 1'b0;
      ready_q       <= 1'b0;
      wait_q        <= 1'b0;
      rd_q          <= 32'd0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= 48'd0;
      end
    end else begin
      state_q       <= state_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      man_a_q       <= man_a_d;
      man_b_q       <= man_b_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      nv_q          <= nv_d;
      mul_cnt_q     <= mul_cnt_d;
      res_q         <= res_d;
      wr_q          <= wr_d;
      ready_q       <= ready_d;
      wait_q        <= wait_d;
      rd_q          <= rd_d;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign pcpi_wr    = wr_q;
  assign pcpi_ready = ready_q;
  assign pcpi_wait  = wait_q;
  assign pcpi_rd    = rd_q;
  assign dbg_state  = state_q;

`ifdef FMUL_FLAGS_EN
  // Flags for the result are captured alongside it in NORM and presented
  // with pcpi_ready. Special results are exact; only NV can be raised.
  logic [4:0] flags_res_q, flags_res_d;
  logic [4:0] fflags_q, fflags_d;

  always_comb begin
    flags_res_d = flags_res_q;
    fflags_d    = fflags_q;
    if (state_q == ST_NORM) begin
      if (special_q) begin
        flags_res_d = {nv_q, 4'b0000};
      end else begin
        flags_res_d = {1'b0, 1'b0, rp_of, rp_uf, rp_nx};
      end
    end
    if (state_q == ST_DONE) begin
      fflags_d = flags_res_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flags_res_q <= 5'd0;
      fflags_q    <= 5'd0;
    end else begin
      flags_res_q <= flags_res_d;
      fflags_q    <= fflags_d;
    end
  end

  assign fflags = fflags_q;
`else
  logic unused_flags;
  assign unused_flags = rp_of ^ rp_uf ^ rp_nx ^ nv_q;
`endif

endmodule

// File: tb/tb_pcpi_fmul.sv
// ---------------------------------------------------------------------------
// tb_pcpi_fmul: directed self-checking bench for pcpi_fmul (MUL_STAGES=1).
// Expected products are hand-computed binary32 patterns.
// ---------------------------------------------------------------------------
module tb_pcpi_fmul;

  localparam logic [31:0] FMUL_INSN    = 32'h1031_0253;
  localparam logic [31:0] FMUL_INSN_RM = 32'h1031_7253;
  localparam logic [31:0] OTHER_INSN   = 32'h0220_8033;
  localparam int          LATENCY      = 4;
  localparam int          TIMEOUT      = 20;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic [2:0]  dbg_state;
`ifdef FMUL_FLAGS_EN
  logic [4:0]  fflags;
`endif

  int n_cmp;
  int n_fail;

  pcpi_fmul #(.MUL_STAGES(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .dbg_state  (dbg_state)
`ifdef FMUL_FLAGS_EN
    ,
    .fflags     (fflags)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, then follow it to completion. When hold_valid is
  // clear, pcpi_valid drops right after the sampling edge.
  task automatic run_op(input string tag, input logic [31:0] insn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input bit hold_valid);
    int lat;
    lat = 0;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) pcpi_valid = 1'b0;
    check({tag, ".wait"}, {31'd0, pcpi_wait}, 32'd1);
    check({tag, ".early_ready"}, {31'd0, pcpi_ready}, 32'd0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (pcpi_ready) begin
        lat = c;
        break;
      end
    end
    pcpi_valid = 1'b0;
    check({tag, ".latency"}, lat, LATENCY);
    check({tag, ".rd"}, pcpi_rd, exp_rd);
    check({tag, ".wr"}, {31'd0, pcpi_wr}, 32'd1);
    check({tag, ".wait_done"}, {31'd0, pcpi_wait}, 32'd0);
    @(negedge clk);
    check({tag, ".ready_pulse"}, {30'd0, pcpi_ready, pcpi_wr}, 32'd0);
    check({tag, ".rd_hold"}, pcpi_rd, exp_rd);
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = 32'd0;
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.outs", {pcpi_wr, pcpi_ready, pcpi_wait, 29'd0}, 32'd0);
    check("reset.rd", pcpi_rd, 32'd0);
    check("reset.state", {29'd0, dbg_state}, 32'd0);
    resetn = 1'b1;

    // Main function
    run_op("two_x_three",  FMUL_INSN, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);
    run_op("1p5_sq",       FMUL_INSN, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1);
    run_op("neg_one",      FMUL_INSN, 32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b1);
    run_op("rne_tie",      FMUL_INSN, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b1);
    run_op("round_carry",  FMUL_INSN, 32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000, 1'b1);
    run_op("rm_ignored",   FMUL_INSN_RM, 32'h4000_0000, 32'hC040_0000, 32'hC0C0_0000, 1'b1);
    run_op("valid_drop",   FMUL_INSN, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 1'b0);

    // Specials and range boundaries
    run_op("inf_x_zero",   FMUL_INSN, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1);
    run_op("qnan_in",      FMUL_INSN, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1);
    run_op("snan_in",      FMUL_INSN, 32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000, 1'b1);
    run_op("inf_x_neg",    FMUL_INSN, 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b1);
    run_op("negzero_x_3",  FMUL_INSN, 32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1'b1);
    run_op("subnorm_flush",FMUL_INSN, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b1);
    run_op("overflow",     FMUL_INSN, 32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 1'b1);
    run_op("overflow_neg", FMUL_INSN, 32'hFF7F_FFFF, 32'h4000_0000, 32'hFF80_0000, 1'b1);
    run_op("underflow",    FMUL_INSN, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1);

    // Non-FMUL instruction must get no response
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = OTHER_INSN;
    pcpi_rs1   = 32'h4000_0000;
    pcpi_rs2   = 32'h4040_0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("other_insn.outs", {29'd0, pcpi_wait, pcpi_ready, pcpi_wr}, 32'd0);
    end
    pcpi_valid = 1'b0;

    // Reset in the middle of an operation (rd holds a nonzero value first)
    run_op("pre_reset",    FMUL_INSN, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = FMUL_INSN;
    pcpi_rs1   = 32'h3FC0_0000;
    pcpi_rs2   = 32'h3FC0_0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("abort.in_mul", {29'd0, dbg_state}, 32'd2);
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    #1;
    check("abort.outs", {pcpi_wr, pcpi_ready, pcpi_wait, 29'd0}, 32'd0);
    check("abort.rd", pcpi_rd, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort.no_strobe", {30'd0, pcpi_ready, pcpi_wr}, 32'd0);
    end
    run_op("post_reset",   FMUL_INSN, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
